// File: rtl/regfile_banked.sv
// Banked register file: one write port, two registered read ports sharing a bank
// select, and a clear sequencer that zeroes storage. REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_banked #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_W = 5,
    parameter int BANK_W         = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      we,
    input  logic [BANK_W-1:0]         wbank,
    input  logic [REGFILE_ADDR_W-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0]     rd,
    input  logic                      re,
    input  logic [BANK_W-1:0]         rbank,
    input  logic [REGFILE_ADDR_W-1:0] a_ra,
    input  logic [REGFILE_ADDR_W-1:0] a_rb,
    output logic [DATA_WIDTH-1:0]     ra,
    output logic [DATA_WIDTH-1:0]     rb,
    output logic                      rvalid,
    input  logic                      clr_req,
    input  logic [BANK_W-1:0]         clr_bank,
    output logic                      clr_busy,
    output logic                      clr_done
);

    localparam int unsigned AW    = REGFILE_ADDR_W;
    localparam int unsigned CW    = BANK_W + REGFILE_ADDR_W;
    localparam int unsigned WORDS = 2 ** CW;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP_ALL,
        SWEEP_BANK
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [BANK_W-1:0]     bank_q, bank_next;
    logic                  done_next;
    logic                  sweep_we;
    logic [CW-1:0]         sweep_addr;
    logic                  user_we;
    logic                  rd_ok;
    logic                  rd_mask;
    logic [DATA_WIDTH-1:0] ra_next, rb_next;
    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bank_next  = bank_q;
        done_next  = 1'b0;
        sweep_we   = 1'b0;
        sweep_addr = cnt;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = SWEEP_BANK;
                    bank_next  = clr_bank;
                    cnt_next   = '0;
                end
            end
            SWEEP_ALL: begin
                sweep_we = 1'b1;
                if (cnt == '1) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SWEEP_BANK: begin
                sweep_we   = 1'b1;
                sweep_addr = {bank_q, cnt[AW-1:0]};
                if (cnt[AW-1:0] == '1) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A bank under clear rejects user writes and reads back as zero.
    always_comb begin
        user_we = we && (state == IDLE || (state == SWEEP_BANK && wbank != bank_q));
        rd_ok   = re && (state != SWEEP_ALL);
        rd_mask = (state == SWEEP_BANK) && (rbank == bank_q);
        ra_next = mem[{rbank, a_ra}];
        rb_next = mem[{rbank, a_rb}];
`ifdef REGFILE_BYPASS_EN
        if (user_we && rbank == wbank && a_ra == a_rd) ra_next = rd;
        if (user_we && rbank == wbank && a_rb == a_rd) rb_next = rd;
`endif
        if (rd_mask) begin
            ra_next = '0;
            rb_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SWEEP_ALL;
            cnt      <= '0;
            bank_q   <= '0;
            ra       <= '0;
            rb       <= '0;
            rvalid   <= 1'b0;
            clr_done <= 1'b0;
        end else if (en) begin
            state    <= state_next;
            cnt      <= cnt_next;
            bank_q   <= bank_next;
            clr_done <= done_next;
            rvalid   <= rd_ok;
            if (rd_ok) begin
                ra <= ra_next;
                rb <= rb_next;
            end
        end else begin
            rvalid   <= 1'b0;
            clr_done <= 1'b0;
        end
    end

    // Sweep and user writes never target the same bank, so both may land in one cycle.
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            if (sweep_we) mem[sweep_addr] <= '0;
            if (user_we)  mem[{wbank, a_rd}] <= rd;
        end
    end

    assign clr_busy = (state != IDLE);

endmodule

// File: tb/tb_regfile_banked.sv
// Self-checking bench for regfile_banked: table vectors, hand-written clear sequences,
// and randomized traffic against a word-array reference model.
module tb_regfile_banked;

    logic        clk;
    logic        rst, en, we, re, clr_req;
    logic [1:0]  wbank, rbank, clr_bank;
    logic [4:0]  a_rd, a_ra, a_rb;
    logic [31:0] rd;
    logic [31:0] ra, rb;
    logic        rvalid, clr_busy, clr_done;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_banked #(.DATA_WIDTH(32), .REGFILE_ADDR_W(5), .BANK_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .wbank(wbank), .a_rd(a_rd), .rd(rd),
        .re(re), .rbank(rbank), .a_ra(a_ra), .a_rb(a_rb), .ra(ra), .rb(rb),
        .rvalid(rvalid), .clr_req(clr_req), .clr_bank(clr_bank),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word array plus a description of the clear in progress.
    logic [31:0] m [4][32];
    int          sweep_kind;   // 0 none, 1 whole file, 2 single bank
    int          sweep_pos;    // words already cleared
    int          sweep_bank;
    logic [31:0] e_ra, e_rb;
    logic        e_rvalid, e_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_step();
        logic [31:0] va, vb;
        bit          uw;
        if (rst) begin
            sweep_kind = 1; sweep_pos = 0;
            e_ra = '0; e_rb = '0; e_rvalid = 1'b0; e_done = 1'b0;
            return;
        end
        if (!en) begin
            e_rvalid = 1'b0; e_done = 1'b0;
            return;
        end
        uw = we && sweep_kind != 1 && !(sweep_kind == 2 && int'(wbank) == sweep_bank);
        e_rvalid = re && sweep_kind != 1;
        if (e_rvalid) begin
            va = m[rbank][a_ra];
            vb = m[rbank][a_rb];
`ifdef REGFILE_BYPASS_EN
            if (uw && rbank == wbank && a_ra == a_rd) va = rd;
            if (uw && rbank == wbank && a_rb == a_rd) vb = rd;
`endif
            if (sweep_kind == 2 && int'(rbank) == sweep_bank) begin va = '0; vb = '0; end
            e_ra = va; e_rb = vb;
        end
        if (uw) m[wbank][a_rd] = rd;
        e_done = 1'b0;
        if (sweep_kind == 1) begin
            m[sweep_pos / 32][sweep_pos % 32] = '0;
            sweep_pos++;
            if (sweep_pos == 128) begin sweep_kind = 0; e_done = 1'b1; end
        end else if (sweep_kind == 2) begin
            m[sweep_bank][sweep_pos] = '0;
            sweep_pos++;
            if (sweep_pos == 32) begin sweep_kind = 0; e_done = 1'b1; end
        end else if (clr_req) begin
            sweep_kind = 2; sweep_bank = int'(clr_bank); sweep_pos = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("ra", ra, e_ra);
        chk("rb", rb, e_rb);
        chk("rvalid", 32'(rvalid), 32'(e_rvalid));
        chk("clr_done", 32'(clr_done), 32'(e_done));
        chk("clr_busy", 32'(clr_busy), 32'(sweep_kind != 0));
    endtask

    task automatic idle_inputs();
        rst = 0; en = 1; we = 0; re = 0; clr_req = 0;
        wbank = 0; rbank = 0; clr_bank = 0; a_rd = 0; a_ra = 0; a_rb = 0; rd = 0;
    endtask

    typedef struct {
        logic        en, we;
        logic [1:0]  wbank;
        logic [4:0]  a_rd;
        logic [31:0] rd;
        logic        re;
        logic [1:0]  rbank;
        logic [4:0]  a_ra, a_rb;
        logic [31:0] x_ra, x_rb;
        logic        x_rvalid;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, dones;
        logic [31:0] byp;
        for (int b = 0; b < 4; b++) for (int w = 0; w < 32; w++) m[b][w] = '0;
        sweep_kind = 0; sweep_pos = 0; sweep_bank = 0;
        e_ra = '0; e_rb = '0; e_rvalid = 0; e_done = 0;
`ifdef REGFILE_BYPASS_EN
        byp = 32'h12345678;
`else
        byp = 32'h0;
`endif
        //          en we wb a_rd rd            re rb a_ra a_rb x_ra          x_rb          xv
        vecs[0] = '{1, 1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        32'h0,        0};
        vecs[1] = '{1, 0, 0, 0, 32'h0,        1, 1, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[2] = '{1, 0, 0, 0, 32'h0,        1, 0, 3, 3, 32'h0,        32'h0,        1};
        vecs[3] = '{1, 0, 0, 0, 32'h0,        1, 2, 3, 3, 32'h0,        32'h0,        1};
        vecs[4] = '{1, 0, 0, 0, 32'h0,        1, 3, 3, 3, 32'h0,        32'h0,        1};
        vecs[5] = '{1, 1, 0, 7, 32'h12345678, 1, 0, 7, 3, byp,          32'h0,        1};
        vecs[6] = '{1, 0, 0, 0, 32'h0,        1, 0, 7, 7, 32'h12345678, 32'h12345678, 1};
        vecs[7] = '{1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h12345678, 32'h12345678, 0};
        vecs[8] = '{0, 1, 1, 3, 32'h0BADF00D, 1, 1, 3, 3, 32'h12345678, 32'h12345678, 0};
        vecs[9] = '{1, 0, 0, 0, 32'h0,        1, 1, 3, 7, 32'hDEADBEEF, 32'h0,        1};

        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;

        // Power-up sweep of the whole file.
        n = 0;
        while (clr_busy && n < 300) begin cycle(); n++; end
        chk("init_busy_cycles", 32'(n), 32'd128);
        chk("init_done_pulse", 32'(clr_done), 32'd1);
        re = 1; rbank = 3; a_ra = 31; a_rb = 31;
        cycle();
        chk("b3a31_ra", ra, 32'h0);
        chk("b3a31_rvalid", 32'(rvalid), 32'd1);
        chk("done_dropped", 32'(clr_done), 32'd0);

        for (int i = 0; i < 10; i++) begin
            en = vecs[i].en; we = vecs[i].we; wbank = vecs[i].wbank; a_rd = vecs[i].a_rd;
            rd = vecs[i].rd; re = vecs[i].re; rbank = vecs[i].rbank;
            a_ra = vecs[i].a_ra; a_rb = vecs[i].a_rb;
            cycle();
            chk($sformatf("vec%0d_ra", i), ra, vecs[i].x_ra);
            chk($sformatf("vec%0d_rb", i), rb, vecs[i].x_rb);
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].x_rvalid));
        end
        idle_inputs();

        // Fill banks 1 and 2, then clear bank 2 alone.
        for (int i = 0; i < 32; i++) begin
            we = 1; wbank = 2; a_rd = 5'(i); rd = 32'(i + 1); cycle();
            wbank = 1; rd = 32'hA0 + 32'(i); cycle();
        end
        idle_inputs();
        clr_req = 1; clr_bank = 2;
        cycle();
        idle_inputs();
        n = 0;
        while (clr_busy && n < 200) begin
            idle_inputs();
            if (n == 3) begin
                we = 1; wbank = 2; a_rd = 2; rd = 32'hFFFFFFFF;
                re = 1; rbank = 2; a_ra = 20; a_rb = 0;
            end
            if (n == 5) begin re = 1; rbank = 1; a_ra = 7; a_rb = 8; end
            if (n == 6) begin clr_req = 1; clr_bank = 1; end
            cycle();
            if (n == 3) chk("masked_read", ra, 32'h0);
            if (n == 5) chk("other_bank_read", ra, 32'hA7);
            n++;
        end
        chk("bank_busy_cycles", 32'(n), 32'd32);
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            re = 1; rbank = 2; a_ra = 5'(i); a_rb = 5'(31 - i); cycle();
            chk("bank2_cleared", ra, 32'h0);
            rbank = 1; cycle();
            chk("bank1_intact", ra, 32'hA0 + 32'(i));
        end
        idle_inputs();

        // Freeze the bank sweep for five cycles.
        clr_req = 1; clr_bank = 0;
        cycle();
        n = 0;
        while (clr_busy && n < 200) begin
            idle_inputs();
            if (n >= 10 && n < 15) begin
                en = 0; we = 1; wbank = 1; a_rd = 9; rd = 32'h55;
                re = 1; rbank = 1; a_ra = 1; a_rb = 2;
            end
            cycle();
            n++;
        end
        chk("frozen_busy_cycles", 32'(n), 32'd37);
        idle_inputs();
        re = 1; rbank = 1; a_ra = 9; a_rb = 9;
        cycle();
        chk("frozen_write_blocked", ra, 32'hA9);
        idle_inputs();

        // Reset in the middle of a bank sweep.
        clr_req = 1; clr_bank = 3;
        cycle();
        idle_inputs();
        dones = 0;
        for (int i = 0; i < 10; i++) begin cycle(); dones += int'(clr_done); end
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_busy", 32'(clr_busy), 32'd1);
        n = 0;
        while (clr_busy && n < 300) begin cycle(); n++; dones += int'(clr_done); end
        cycle();
        dones += int'(clr_done);
        chk("restart_busy_cycles", 32'(n), 32'd128);
        chk("restart_done_count", 32'(dones), 32'd1);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 499) == 0);
            en      = ($urandom_range(0, 9) != 0);
            we      = 1'($urandom_range(0, 1));
            wbank   = 2'($urandom);
            a_rd    = 5'($urandom);
            rd      = $urandom;
            re      = 1'($urandom_range(0, 1));
            rbank   = 2'($urandom);
            a_ra    = 5'($urandom);
            a_rb    = ($urandom_range(0, 3) == 0) ? a_ra : 5'($urandom);
            if ($urandom_range(0, 3) == 0) begin rbank = wbank; a_ra = a_rd; end
            clr_req = ($urandom_range(0, 39) == 0);
            clr_bank = 2'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
Parametrised multi-bank register file for the sample-rate-converter datapath. It holds one bank of coefficients/state per channel, with one write port, two registered read ports sharing a bank select, and read-during-write forwarding. A built-in clear sequencer zeroes every bank after reset and zeroes single banks on request, one word per cycle, so storage needs no wide reset fan-out.

Parameters:
DATA_WIDTH, 32, word width
REGFILE_ADDR_W, 5, word address width; words per bank = 2**REGFILE_ADDR_W
BANK_W, 2, bank select width; banks = 2**BANK_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high; overrides en
en  in  1  global enable; en=0 freezes all state, including the sequencer
we  in  1  write request
wbank  in  BANK_W  write bank
a_rd  in  REGFILE_ADDR_W  write address
rd  in  DATA_WIDTH  write data
re  in  1  read request
rbank  in  BANK_W  read bank, shared by both ports
a_ra  in  REGFILE_ADDR_W  read address, port A
a_rb  in  REGFILE_ADDR_W  read address, port B
ra  out  DATA_WIDTH  port A data, registered
rb  out  DATA_WIDTH  port B data, registered
rvalid  out  1  ra/rb updated this cycle
clr_req  in  1  request clear of clr_bank
clr_bank  in  BANK_W  bank to clear
clr_busy  out  1  sequencer active
clr_done  out  1  one-cycle pulse, sweep finished

Behaviour:
- Reset (rst=1 at clk edge): ra=0, rb=0, rvalid=0, clr_done=0, clr_busy=1, FSM enters SWEEP_ALL with counter=0. Storage is not reset directly.
- FSM states:
  - IDLE:
    - en & clr_req -> SWEEP_BANK; latch clr_bank; counter=0.
  - SWEEP_ALL:
    - Each en cycle writes 0 to word {bank,addr}=counter, then counter++.
    - After word 2**(BANK_W+REGFILE_ADDR_W)-1 -> IDLE.
  - SWEEP_BANK:
    - Each en cycle writes 0 to latched bank, addr=counter, then counter++.
    - After addr 2**REGFILE_ADDR_W-1 -> IDLE.
- clr_busy=1 exactly while state is not IDLE. clr_done=1 for the single cycle after the last sweep write.
- clr_req while busy is ignored and is not queued.
- SWEEP_ALL: we and re are ignored; rvalid=0; ra/rb hold.
- SWEEP_BANK, user writes:
  - A write to the bank under clear is dropped.
  - Writes to other banks proceed normally.
- SWEEP_BANK, user reads:
  - A read with rbank equal to the bank under clear returns 0 on both ports.
  - Other banks read normally.
- Write: en & we (and not dropped) -> mem[wbank][a_rd] <= rd at the edge.
- Read:
  - en & re -> ra <= mem[rbank][a_ra], rb <= mem[rbank][a_rb]; rvalid=1 on the next cycle.
  - Latency is 1 clock.
  - en & !re -> ra/rb hold, rvalid=0.
- en=0: no writes, no reads, FSM and counter hold, rvalid=0, clr_done=0; ra/rb hold.
- rst mid-sweep: the sweep restarts as SWEEP_ALL from counter=0.
- Both read ports may address the same word; both return the same value.
- Counter width is BANK_W+REGFILE_ADDR_W; it never wraps past its terminal value because the FSM exits on the terminal value.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read in the same cycle as a non-dropped write with rbank==wbank and a_ra (or a_rb)==a_rd returns the new rd on that port.
- Undefined: such a read returns the old stored value; write-first semantics are then visible only from the following cycle.
- Clear masking takes precedence over bypass in both builds.

Test Plan:
- Default params, pulse rst for 1 cycle, hold en=1 -> clr_busy=1 for 128 cycles, clr_done pulses at cycle 129, then a read of bank3 addr31 gives ra=0, rvalid=1 one cycle after re.
- Write bank1 addr3 0xDEADBEEF; next cycle re with rbank=1, a_ra=3, a_rb=3 -> ra=rb=0xDEADBEEF one cycle later; other banks at addr3 still read 0.
- Same-cycle write bank0 addr7 0x12345678 and read bank0 a_ra=7 (old value 0x0) -> ra=0x12345678 with REGFILE_BYPASS_EN, ra=0x0 without; the next read gives 0x12345678 in both builds.
- Fill bank2 addr i with i+1 and bank1 addr i with 0xA0+i; clr_req, clr_bank=2 -> busy for 32 cycles; a write to bank2 during the sweep is dropped; reading bank2 during the sweep gives 0; afterwards bank2 is all 0 and bank1 is intact.
- Start SWEEP_BANK, drop en for 5 cycles mid-sweep -> counter, clr_busy and ra/rb frozen, no writes take effect; the sweep completes 5 cycles late.
- Assert rst at sweep word 10 of SWEEP_BANK -> SWEEP_ALL restarts, busy for a full 128 cycles, one clr_done pulse only.
